// File: rtl/imm_unit.sv
// imm_unit: 2*REG_BITS immediate register. It is parallel-loaded by the decoder or fetched little-endian from the prefetch queue.
// It is served NSHIFT bits per step, with rotate or serial write-back.
module imm_unit #(
  parameter int REG_BITS = 8,
  parameter int NSHIFT   = 2
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  imm_load,
  input  logic [2*REG_BITS-1:0] imm_value,
  input  logic                  load_imm16,
  output logic                  imm16_loaded,
  input  logic                  q_valid,
  input  logic [REG_BITS-1:0]   q_data,
  output logic                  q_pop,
  input  logic                  flush,
  input  logic                  next_imm_data,
  output logic [NSHIFT-1:0]     imm_data_in,
  input  logic                  wb_en,
  input  logic [NSHIFT-1:0]     imm8_data_out,
  output logic                  imm_aligned,
  output logic                  busy
);
  localparam int IMM_BITS = 2 * REG_BITS;
  localparam int STEPS    = IMM_BITS / NSHIFT;
  localparam int SW       = STEPS > 1 ? $clog2(STEPS) : 1;

  typedef enum logic [1:0] {IDLE, FETCH_LO, FETCH_HI, DONE} state_t;

  state_t                state_q, state_d;
  logic [IMM_BITS-1:0]   imm_q, imm_d;
  logic [SW-1:0]         step_q, step_d;
  logic [NSHIFT-1:0]     fill;

  assign busy         = state_q == FETCH_LO || state_q == FETCH_HI;
  assign q_pop        = q_valid && busy && !flush && !imm_load;
  assign imm16_loaded = state_q == DONE;
  assign imm_data_in  = imm_q[NSHIFT-1:0];
  assign imm_aligned  = step_q == '0;
  assign fill         = wb_en ? imm8_data_out : imm_q[NSHIFT-1:0];

  always_comb begin
    state_d = state_q;
    imm_d   = imm_q;
    step_d  = step_q;
    if (next_imm_data && !busy) begin
      imm_d  = {fill, imm_q[IMM_BITS-1:NSHIFT]};
      step_d = step_q == SW'(STEPS - 1) ? '0 : step_q + 1'b1;
    end
    case (state_q)
      IDLE:     state_d = load_imm16 ? FETCH_LO : IDLE;
      FETCH_LO: if (flush) state_d = IDLE;
                else if (q_pop) begin
                  imm_d[REG_BITS-1:0] = q_data;
                  state_d = FETCH_HI;
                end
      FETCH_HI: if (flush) state_d = IDLE;
                else if (q_pop) begin
                  imm_d[IMM_BITS-1:REG_BITS] = q_data;
                  step_d  = '0;
                  state_d = DONE;
                end
      default:  state_d = IDLE;
    endcase
    // Decoder load overrides fetch, flush and shift alike
    if (imm_load) begin
      imm_d   = imm_value;
      step_d  = '0;
      state_d = IDLE;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      imm_q   <= '0;
      step_q  <= '0;
    end else begin
      state_q <= state_d;
      imm_q   <= imm_d;
      step_q  <= step_d;
    end
  end
endmodule
